// File: rtl/uart_wb_bridge_burst.sv
// UART byte-stream to Wishbone master bridge: binary command frames, incrementing
// bursts, bus timeout, one status byte per command and a saturating error counter.
module uart_wb_bridge_burst #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            app_clk,
    input  logic            arst_n,
    input  logic            cfg_enb,
    input  logic            rx_wr,
    input  logic [7:0]      rx_data,
    output logic            rx_ready,
    output logic            tx_data_avail,
    output logic [7:0]      tx_data,
    input  logic            tx_rd,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic            wbm_we_o,
    output logic [DW-1:0]   wbm_dat_o,
    output logic [DW/8-1:0] wbm_sel_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    output logic            busy,
    output logic [7:0]      err_cnt
);
    localparam int AB = AW / 8;
    localparam int DB = DW / 8;
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [4:0] MAX_LEN = 5'(MAX_BURST);
    localparam logic [7:0] STS_OK  = 8'h00;
    localparam logic [7:0] STS_ERR = 8'h01;
    localparam logic [7:0] STS_TMO = 8'h02;
    localparam logic [7:0] STS_LEN = 8'h03;

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WB_REQ, RESP_DATA, DRAIN, RESP_STS
    } state_t;

    state_t        state, next_state;
    logic          is_write;
    logic [4:0]    beats_left;
    logic [7:0]    byte_cnt;   // bytes left in the current field / bytes left to send
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    status;

    logic       rx_fire, tx_done, last_byte, timeout, bus_fail, more_beats;
    logic [4:0] cmd_len;
    logic [7:0] drain_bytes;

    assign rx_ready    = cfg_enb && (state inside {IDLE, ADDR, WDATA, DRAIN});
    assign rx_fire     = rx_wr && rx_ready;
    assign tx_done     = tx_data_avail && tx_rd;
    assign last_byte   = (byte_cnt == 8'd1);
    assign cmd_len     = {1'b0, rx_data[3:0]} + 5'd1;
    assign timeout     = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign bus_fail    = wbm_err_i || (timeout && !wbm_ack_i);
    assign more_beats  = (beats_left > 5'd1);
    assign drain_bytes = {3'b000, beats_left - 5'd1} * 8'(DB);

    assign wbm_stb_o = (state == WB_REQ);
    assign wbm_cyc_o = wbm_stb_o;
    assign wbm_we_o  = wbm_stb_o && is_write;
    assign wbm_adr_o = adr;
    assign wbm_dat_o = wdata;
    assign wbm_sel_o = '1;
    assign busy      = (state != IDLE);

    always_ff @(posedge app_clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (rx_fire) next_state = (cmd_len > MAX_LEN) ? RESP_STS : ADDR;
            ADDR:      if (rx_fire && last_byte) next_state = is_write ? WDATA : WB_REQ;
            WDATA:     if (rx_fire && last_byte) next_state = WB_REQ;
            WB_REQ: begin
                if (bus_fail)       next_state = (is_write && more_beats) ? DRAIN : RESP_STS;
                else if (wbm_ack_i) next_state = !is_write ? RESP_DATA : (more_beats ? WDATA : RESP_STS);
            end
            RESP_DATA: if (tx_done && byte_cnt == 8'd0) next_state = (beats_left != 5'd0) ? WB_REQ : RESP_STS;
            DRAIN:     if (rx_fire && last_byte) next_state = RESP_STS;
            RESP_STS:  if (tx_done && byte_cnt == 8'd0) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (!cfg_enb) next_state = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
    always_ff @(posedge app_clk or negedge arst_n) begin
        if (!arst_n) begin
            is_write      <= 1'b0;
            beats_left    <= '0;
            byte_cnt      <= '0;
            adr           <= '0;
            wdata         <= '0;
            rdata         <= '0;
            tmo_cnt       <= '0;
            status        <= STS_OK;
            tx_data_avail <= 1'b0;
            tx_data       <= '0;
            err_cnt       <= '0;
        end else if (!cfg_enb) begin
            tx_data_avail <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            tmo_cnt <= '0;
            if (tx_done) tx_data_avail <= 1'b0;
            case (state)
                IDLE: if (rx_fire) begin
                    is_write   <= rx_data[7];
                    beats_left <= cmd_len;
                    byte_cnt   <= (cmd_len > MAX_LEN) ? 8'd1 : 8'(AB);
                    status     <= STS_LEN;
                end
                ADDR: if (rx_fire) begin
                    adr      <= AW'({adr, rx_data});
                    byte_cnt <= last_byte ? 8'(DB) : byte_cnt - 8'd1;
                end
                WDATA: if (rx_fire) begin
                    wdata    <= DW'({wdata, rx_data});
                    byte_cnt <= byte_cnt - 8'd1;
                end
                WB_REQ: begin
                    if (bus_fail) begin
                        status   <= wbm_err_i ? STS_ERR : STS_TMO;
                        byte_cnt <= (is_write && more_beats) ? drain_bytes : 8'd1;
                    end else if (wbm_ack_i) begin
                        status     <= STS_OK;
                        beats_left <= beats_left - 5'd1;
                        adr        <= adr + AW'(DB);
                        if (!is_write) rdata <= wbm_dat_i;
                        byte_cnt   <= (!is_write || more_beats) ? 8'(DB) : 8'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP_DATA: begin
                    if (!tx_data_avail && byte_cnt != 8'd0) begin
                        tx_data       <= rdata[DW-1 -: 8];
                        rdata         <= DW'({rdata, 8'h00});
                        tx_data_avail <= 1'b1;
                        byte_cnt      <= byte_cnt - 8'd1;
                    end
                    if (tx_done && byte_cnt == 8'd0) byte_cnt <= 8'd1;
                end
                DRAIN: if (rx_fire) byte_cnt <= last_byte ? 8'd1 : byte_cnt - 8'd1;
                RESP_STS: begin
                    if (!tx_data_avail && byte_cnt != 8'd0) begin
                        tx_data       <= status;
                        tx_data_avail <= 1'b1;
                        byte_cnt      <= 8'd0;
                    end
                    if (tx_done && byte_cnt == 8'd0 && status != STS_OK && err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_wb_bridge_burst.sv
// Self-checking bench: directed scenarios plus random commands, checked against a
// memory-level model of the command protocol.
module tb_uart_wb_bridge_burst;
    localparam int AW = 32, DW = 32, MAX_BURST = 8, TIMEOUT_CYC = 16;

    logic app_clk, arst_n, cfg_enb, rx_wr, rx_ready, tx_data_avail, tx_rd;
    logic [7:0] rx_data, tx_data, err_cnt;
    logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i, busy;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o, wbm_dat_i;
    logic [DW/8-1:0] wbm_sel_o;

    uart_wb_bridge_burst #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .app_clk(app_clk), .arst_n(arst_n), .cfg_enb(cfg_enb),
        .rx_wr(rx_wr), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data_avail(tx_data_avail), .tx_data(tx_data), .tx_rd(tx_rd),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
        .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .busy(busy), .err_cnt(err_cnt)
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; } bus_t;

    int n_checks = 0, n_pass = 0;
    bus_t bus_log[$];
    logic [7:0] tx_q[$];
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] fixed_wdata[$];
    int model_err = 0;
    int beat = 0, ack_lat = 0, err_beat = 0, stb_cycles = 0, last_stb_len = 0, stb_hold_err = 0;
    bit no_resp = 0, drove_resp = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction
    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Wishbone slave: logs each beat on its first stb cycle, answers after ack_lat cycles.
    initial begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
        forever begin
            @(negedge app_clk);
            if (drove_resp && wbm_stb_o) stb_hold_err++;
            drove_resp = 0;
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            if (wbm_stb_o) begin
                stb_cycles++;
                if (stb_cycles == 1) begin
                    beat++;
                    bus_log.push_back('{adr: wbm_adr_o, we: wbm_we_o, dat: wbm_dat_o, sel: wbm_sel_o});
                end
                if (!no_resp && stb_cycles == ack_lat + 1) begin
                    drove_resp = 1;
                    if (beat == err_beat) wbm_err_i = 1'b1;
                    else begin
                        wbm_ack_i = 1'b1;
                        if (wbm_we_o) slave_mem[wbm_adr_o] = wbm_dat_o;
                        else wbm_dat_i = slave_rd(wbm_adr_o);
                    end
                end
            end else begin
                if (stb_cycles != 0) last_stb_len = stb_cycles;
                stb_cycles = 0;
            end
        end
    end

    // TX consumer with random back-pressure.
    initial begin
        tx_rd = 1'b0;
        forever begin
            @(negedge app_clk);
            tx_rd = 1'b0;
            if (tx_data_avail && $urandom_range(0, 3) != 0) begin
                tx_q.push_back(tx_data);
                tx_rd = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge app_clk);
            if (rx_ready) begin rx_wr = 1'b1; rx_data = b; done = 1; end
        end
        if (done) begin @(negedge app_clk); rx_wr = 1'b0; end
        else check("rx_ready_wait", 64'(done), 64'(1));
    endtask

    task automatic clear_env(input int lat, input int eb, input bit nr);
        bus_log.delete(); tx_q.delete();
        beat = 0; ack_lat = lat; err_beat = eb; no_resp = nr; stb_hold_err = 0;
    endtask

    // Predicts bus beats and TX bytes from the protocol rules, drives the frame, compares.
    task automatic run_cmd(input string tag, input logic [7:0] cmd, input logic [31:0] addr,
                           input int lat, input int eb, input bit nr);
        int len; bit wr, done; logic [7:0] sts;
        logic [31:0] a, d, rv;
        logic [7:0] host[$]; logic [7:0] exp_tx[$]; bus_t exp_bus[$];
        clear_env(lat, eb, nr);
        len = int'(cmd[3:0]) + 1;
        wr  = cmd[7];
        host.push_back(cmd);
        sts = 8'h00;
        if (len > MAX_BURST) sts = 8'h03;
        else begin
            for (int k = 3; k >= 0; k--) host.push_back(addr[8*k +: 8]);
            for (int i = 1; i <= len; i++) begin
                a = addr + 32'(4 * (i - 1));
                d = (fixed_wdata.size() != 0) ? fixed_wdata.pop_front() : $urandom;
                if (wr) for (int k = 3; k >= 0; k--) host.push_back(d[8*k +: 8]);
                if (sts == 8'h00) begin
                    exp_bus.push_back('{adr: a, we: wr, dat: d, sel: 4'hF});
                    if (nr) sts = 8'h02;
                    else if (i == eb) sts = 8'h01;
                    else if (wr) model_mem[a] = d;
                    else begin
                        rv = model_rd(a);
                        for (int k = 3; k >= 0; k--) exp_tx.push_back(rv[8*k +: 8]);
                    end
                end
            end
        end
        exp_tx.push_back(sts);
        if (sts != 8'h00 && model_err < 255) model_err++;

        foreach (host[i]) send_byte(host[i]);
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge app_clk);
            if (tx_q.size() >= exp_tx.size() && !busy) done = 1;
        end
        if (!done) check({tag, ".idle_wait"}, 64'(done), 64'(1));

        check({tag, ".tx_count"}, 64'(tx_q.size()), 64'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check($sformatf("%s.tx[%0d]", tag, i), 64'(tx_q[i]), 64'(exp_tx[i]));
        check({tag, ".beats"}, 64'(bus_log.size()), 64'(exp_bus.size()));
        for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++) begin
            check($sformatf("%s.adr[%0d]", tag, i), 64'(bus_log[i].adr), 64'(exp_bus[i].adr));
            check($sformatf("%s.we[%0d]", tag, i), 64'(bus_log[i].we), 64'(exp_bus[i].we));
            check($sformatf("%s.sel[%0d]", tag, i), 64'(bus_log[i].sel), 64'(4'hF));
            if (exp_bus[i].we) check($sformatf("%s.dat[%0d]", tag, i), 64'(bus_log[i].dat), 64'(exp_bus[i].dat));
        end
        check({tag, ".stb_after_resp"}, 64'(stb_hold_err), 64'(0));
        check({tag, ".err_cnt"}, 64'(err_cnt), 64'(model_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".stb"}, 64'(wbm_stb_o), 64'(0));
        check({tag, ".cyc"}, 64'(wbm_cyc_o), 64'(0));
        check({tag, ".we"}, 64'(wbm_we_o), 64'(0));
        check({tag, ".adr"}, 64'(wbm_adr_o), 64'(0));
        check({tag, ".dat"}, 64'(wbm_dat_o), 64'(0));
        check({tag, ".sel"}, 64'(wbm_sel_o), 64'(4'hF));
        check({tag, ".tx_avail"}, 64'(tx_data_avail), 64'(0));
        check({tag, ".tx_data"}, 64'(tx_data), 64'(0));
        check({tag, ".busy"}, 64'(busy), 64'(0));
        check({tag, ".err_cnt"}, 64'(err_cnt), 64'(0));
    endtask

    task automatic start_burst_until_beat2(input string tag, input logic [31:0] addr);
        bit ok;
        clear_env(3, 0, 0);
        send_byte(8'h03);
        for (int k = 3; k >= 0; k--) send_byte(addr[8*k +: 8]);
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge app_clk);
            if (bus_log.size() >= 2 && wbm_stb_o) ok = 1;
        end
        check({tag, ".beat2_seen"}, 64'(ok), 64'(1));
    endtask

    initial begin
        int len, eb, lat;
        bit nr, wr;
        logic [7:0] cmd;
        logic [31:0] addr;

        arst_n = 1'b0; cfg_enb = 1'b0; rx_wr = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge app_clk);
        check_reset_outputs("reset");
        check("reset.rx_ready", 64'(rx_ready), 64'(0));
        arst_n = 1'b1;
        @(negedge app_clk);
        cfg_enb = 1'b1;
        @(negedge app_clk);
        check("idle.rx_ready", 64'(rx_ready), 64'(1));

        fixed_wdata = {32'hDEAD_BEEF};
        run_cmd("single_write", 8'h80, 32'h1000_0004, 2, 0, 0);

        for (int i = 0; i < 4; i++) begin
            slave_mem[32'h100 + 32'(4*i)] = 32'h1111_1111 * 32'(i + 1);
            model_mem[32'h100 + 32'(4*i)] = 32'h1111_1111 * 32'(i + 1);
        end
        run_cmd("burst_read", 8'h03, 32'h0000_0100, 1, 0, 0);

        run_cmd("write_err", 8'h82, 32'h0000_0020, 1, 2, 0);
        check("write_err.beat3_unwritten", 64'(slave_mem.exists(32'h28)), 64'(0));

        run_cmd("timeout", 8'h00, 32'h0000_0300, 0, 0, 1);
        check("timeout.stb_len", 64'(last_stb_len), 64'(TIMEOUT_CYC));

        run_cmd("bad_len", 8'h0F, 32'h0, 0, 0, 0);
        run_cmd("after_bad_len", 8'h00, 32'h0000_0400, 0, 0, 0);

        run_cmd("wrap_write", 8'h82, 32'hFFFF_FFF8, 0, 0, 0);
        run_cmd("wrap_read", 8'h02, 32'hFFFF_FFF8, 1, 0, 0);

        start_burst_until_beat2("abort", 32'h0000_0200);
        cfg_enb = 1'b0;
        @(negedge app_clk);
        check("abort.stb", 64'(wbm_stb_o), 64'(0));
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.tx_avail", 64'(tx_data_avail), 64'(0));
        check("abort.rx_ready", 64'(rx_ready), 64'(0));
        cfg_enb = 1'b1;
        repeat (2) @(negedge app_clk);
        fixed_wdata = {32'hDEAD_BEEF};
        run_cmd("abort_recover", 8'h80, 32'h1000_0004, 2, 0, 0);

        start_burst_until_beat2("arst", 32'h0000_0200);
        arst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_err = 0;
        @(negedge app_clk);
        arst_n = 1'b1;
        repeat (2) @(negedge app_clk);
        fixed_wdata = {32'hDEAD_BEEF};
        run_cmd("arst_recover", 8'h80, 32'h1000_0004, 2, 0, 0);

        for (int n = 0; n < 30; n++) begin
            wr  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX_BURST + 1, 16) : $urandom_range(1, MAX_BURST);
            cmd = {wr, 3'($urandom_range(0, 7)), 4'(len - 1)};
            addr = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF4 : 32'h1000 + 32'(4 * $urandom_range(0, 31));
            lat = $urandom_range(0, 3);
            eb  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, len) : 0;
            nr  = ($urandom_range(0, 9) == 0);
            run_cmd($sformatf("rand%0d", n), cmd, addr, lat, eb, nr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end
endmodule
